// File: rtl/sw_setctl_if.sv
// Switch-side bundle for sw_setctl: raw switches in, clean control levels and pulses out.
interface sw_setctl_if;
    logic [3:0] SW;
    logic [3:0] sw_db;
    logic       run;
    logic       inc_sec;
    logic       inc_min;
    logic       clr;

    modport master (
        output SW,
        input  sw_db, run, inc_sec, inc_min, clr
    );

    modport slave (
        input  SW,
        output sw_db, run, inc_sec, inc_min, clr
    );
endinterface

// File: rtl/sw_setctl.sv
// Switch input controller: 2-flop sync, per-bit debounce, run/clear control and
// auto-repeating increment pulses for the seconds and minutes counters.
module sw_setctl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned REP_DELAY  = 25000000,
    parameter int unsigned REP_PERIOD = 10000000
) (
    input logic        CLK,
    input logic        RST,
    sw_setctl_if.slave bus
);

    localparam int unsigned DebW   = $clog2(DEB_CYCLES);
    localparam int unsigned RepMax = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned TmrW   = $clog2(RepMax);

    localparam logic [DebW-1:0] DebLast  = DebW'(DEB_CYCLES - 1);
    localparam logic [TmrW-1:0] DelayLd  = TmrW'(REP_DELAY - 1);
    localparam logic [TmrW-1:0] PeriodLd = TmrW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    logic [3:0]      r_sync1, r_sync2;
    logic [3:0]      r_sw_db, r_sw_db_d;
    logic [3:0]      w_sw_db_next;
    logic [DebW-1:0] r_cnt [4];
    logic [DebW-1:0] w_cnt_d [4];
    logic [3:0]      w_rise;
    logic            r_run, w_run_d;
    logic            r_clr;

    rep_state_e      r_state [2];
    rep_state_e      w_state_d [2];
    logic [TmrW-1:0] r_tmr [2];
    logic [TmrW-1:0] w_tmr_d [2];
    logic [1:0]      r_inc, w_inc_d;

    // Debounce: count consecutive clocks of disagreement, adopt the new level at the limit.
    always_comb begin
        w_sw_db_next = r_sw_db;
        for (int b = 0; b < 4; b++) begin
            w_cnt_d[b] = '0;
            if (r_sync2[b] != r_sw_db[b]) begin
                if (r_cnt[b] == DebLast) begin
                    w_sw_db_next[b] = r_sync2[b];
                end else begin
                    w_cnt_d[b] = r_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign w_rise = r_sw_db & ~r_sw_db_d;

    always_comb begin
        w_run_d = r_run;
        if (w_rise[3]) begin
            w_run_d = 1'b0;
        end else if (w_rise[0]) begin
            w_run_d = ~r_run;
        end
    end

    // Increment channels; channel c serves switch bit c+1.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            w_state_d[c] = r_state[c];
            w_tmr_d[c]   = r_tmr[c];
            w_inc_d[c]   = 1'b0;
            if (!r_sw_db[c+1] || r_run || w_run_d || w_rise[3]) begin
                w_state_d[c] = StIdle;
            end else begin
                case (r_state[c])
                    StIdle: begin
                        if (w_rise[c+1]) begin
                            w_inc_d[c]   = 1'b1;
                            w_tmr_d[c]   = DelayLd;
                            w_state_d[c] = StDelay;
                        end
                    end
                    StDelay, StRepeat: begin
                        if (r_tmr[c] == '0) begin
                            w_inc_d[c]   = 1'b1;
                            w_tmr_d[c]   = PeriodLd;
                            w_state_d[c] = StRepeat;
                        end else begin
                            w_tmr_d[c] = r_tmr[c] - 1'b1;
                        end
                    end
                    default: w_state_d[c] = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sw_db   <= '0;
            r_sw_db_d <= '0;
            r_run     <= 1'b0;
            r_clr     <= 1'b0;
            r_inc     <= '0;
            for (int b = 0; b < 4; b++) begin
                r_cnt[b] <= '0;
            end
            for (int c = 0; c < 2; c++) begin
                r_state[c] <= StIdle;
                r_tmr[c]   <= '0;
            end
        end else begin
            r_sync1   <= bus.SW;
            r_sync2   <= r_sync1;
            r_sw_db   <= w_sw_db_next;
            r_sw_db_d <= r_sw_db;
            r_run     <= w_run_d;
            r_clr     <= w_rise[3];
            r_inc     <= w_inc_d;
            for (int b = 0; b < 4; b++) begin
                r_cnt[b] <= w_cnt_d[b];
            end
            for (int c = 0; c < 2; c++) begin
                r_state[c] <= w_state_d[c];
                r_tmr[c]   <= w_tmr_d[c];
            end
        end
    end

    assign bus.sw_db   = r_sw_db;
    assign bus.run     = r_run;
    assign bus.inc_sec = r_inc[0];
    assign bus.inc_min = r_inc[1];
    assign bus.clr     = r_clr;

endmodule

// File: tb/tb_sw_setctl.sv
// Bench for sw_setctl: directed scenarios plus random switch activity, each cycle
// compared against a behavioural model of the switch controller.
module tb_sw_setctl;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    sw_setctl_if bus ();

    sw_setctl #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [3:0] m_hist[$];
    logic [3:0] m_db, m_db_prev;
    int         m_dis [4];
    logic       m_run, m_clr;
    logic [1:0] m_inc;
    bit         m_act [2];
    int         m_start [2];
    int         m_cyc = 0;

    // Observed tallies for directed checks
    int cnt_sec, cnt_min, cnt_clr, run_chg;
    logic last_run;
    int sec_times[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, m_cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {bus.sw_db, bus.run, bus.inc_sec, bus.inc_min, bus.clr};
    endfunction

    function automatic logic [7:0] model_vec();
        return {m_db, m_run, m_inc[0], m_inc[1], m_clr};
    endfunction

    task automatic m_reset();
        m_hist    = '{4'h0, 4'h0};
        m_db      = '0;
        m_db_prev = '0;
        m_run     = 1'b0;
        m_clr     = 1'b0;
        m_inc     = '0;
        for (int b = 0; b < 4; b++) m_dis[b] = 0;
        for (int c = 0; c < 2; c++) begin
            m_act[c]   = 0;
            m_start[c] = 0;
        end
    endtask

    // One clock edge of the reference: sw is what the switches showed before the edge.
    task automatic m_edge(input logic [3:0] sw);
        logic [3:0] s_old, db_new, rise;
        logic       run_new;
        int         d;
        m_cyc++;
        if (!RST) begin
            m_reset();
            return;
        end
        s_old = m_hist.pop_front();
        m_hist.push_back(sw);
        db_new = m_db;
        for (int b = 0; b < 4; b++) begin
            if (s_old[b] != m_db[b]) begin
                m_dis[b]++;
                if (m_dis[b] == int'(DEB)) begin
                    db_new[b] = s_old[b];
                    m_dis[b]  = 0;
                end
            end else begin
                m_dis[b] = 0;
            end
        end
        rise    = m_db & ~m_db_prev;
        run_new = rise[3] ? 1'b0 : (rise[0] ? ~m_run : m_run);
        for (int c = 0; c < 2; c++) begin
            m_inc[c] = 1'b0;
            if (!m_db[c+1] || m_run || run_new || rise[3]) begin
                m_act[c] = 0;
            end else if (!m_act[c]) begin
                if (rise[c+1]) begin
                    m_act[c]   = 1;
                    m_start[c] = m_cyc;
                    m_inc[c]   = 1'b1;
                end
            end else begin
                d = m_cyc - m_start[c];
                m_inc[c] = (d == int'(RD)) || (d > int'(RD) && ((d - int'(RD)) % int'(RP)) == 0);
            end
        end
        m_clr     = rise[3];
        m_run     = run_new;
        m_db_prev = m_db;
        m_db      = db_new;
    endtask

    task automatic clear_tally();
        cnt_sec  = 0;
        cnt_min  = 0;
        cnt_clr  = 0;
        run_chg  = 0;
        last_run = bus.run;
        sec_times.delete();
    endtask

    task automatic cycle(input logic [3:0] sw);
        bus.SW = sw;
        @(posedge CLK);
        m_edge(sw);
        @(negedge CLK);
        chk("outs", 32'(dut_vec()), 32'(model_vec()));
        if (bus.inc_sec) begin
            cnt_sec++;
            sec_times.push_back(m_cyc);
        end
        if (bus.inc_min) cnt_min++;
        if (bus.clr) cnt_clr++;
        if (bus.run !== last_run) run_chg++;
        last_run = bus.run;
    endtask

    task automatic hold(input logic [3:0] sw, input int n);
        for (int i = 0; i < n; i++) cycle(sw);
    endtask

    // Asynchronous reset pulse in mid-cycle, released on the following falling edge.
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b0;
        m_reset();
        #1;
        chk(tag, 32'(dut_vec()), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        logic [3:0] cur;
        int r;
        bus.SW = 4'h0;
        m_reset();
        clear_tally();

        // Reset held with every switch pressed, then released with switches open
        hold(4'hF, 6);
        chk("t1_in_reset", 32'(dut_vec()), 32'h0);
        RST = 1'b1;
        hold(4'h0, 50);
        chk("t1_no_pulses", 32'(cnt_sec + cnt_min + cnt_clr), 32'h0);
        chk("t1_run", 32'(bus.run), 32'h0);

        // Bouncing run switch settles to a single toggle
        clear_tally();
        hold(4'h1, 2);
        hold(4'h0, 2);
        hold(4'h1, 14);
        chk("t2_run_changes", 32'(run_chg), 32'h1);
        chk("t2_run", 32'(bus.run), 32'h1);
        hold(4'h0, 10);

        // Back to hold mode, then auto-repeat on seconds
        hold(4'h1, 10);
        hold(4'h0, 10);
        chk("t3_run_off", 32'(bus.run), 32'h0);
        clear_tally();
        hold(4'h2, 60);
        hold(4'h0, 15);
        chk("t3_sec_pulses", 32'(cnt_sec), 32'd18);
        chk("t3_min_pulses", 32'(cnt_min), 32'h0);
        if (sec_times.size() >= 3) begin
            chk("t3_first_gap", 32'(sec_times[1] - sec_times[0]), 32'(RD));
            chk("t3_repeat_gap", 32'(sec_times[2] - sec_times[1]), 32'(RP));
        end else begin
            chk("t3_pulse_times", 32'(sec_times.size()), 32'd3);
        end

        // Run lockout on minutes
        hold(4'h1, 10);
        hold(4'h0, 10);
        chk("t4_run_on", 32'(bus.run), 32'h1);
        clear_tally();
        hold(4'h4, 30);
        chk("t4_db_follows", 32'(bus.sw_db[2]), 32'h1);
        hold(4'h0, 10);
        chk("t4_min_pulses", 32'(cnt_min), 32'h0);

        // Clear and run toggle debounced together: clear wins
        clear_tally();
        hold(4'h9, 10);
        hold(4'h0, 10);
        chk("t5_clr_pulses", 32'(cnt_clr), 32'h1);
        chk("t5_run", 32'(bus.run), 32'h0);
        chk("t5_run_changes", 32'(run_chg), 32'h1);

        // Reset while repeating, switch still held
        hold(4'h2, 30);
        async_reset("t6_rst_outs");
        clear_tally();
        hold(4'h2, 40);
        hold(4'h0, 12);
        chk("t6_sec_pulses", 32'(cnt_sec), 32'd11);
        if (sec_times.size() >= 2) begin
            chk("t6_first_gap", 32'(sec_times[1] - sec_times[0]), 32'(RD));
        end else begin
            chk("t6_pulse_times", 32'(sec_times.size()), 32'd2);
        end

        // Random switch activity with occasional glitches and resets
        cur = 4'h0;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                cur[$urandom_range(0, 3)] ^= 1'b1;
                cycle(cur);
            end else if (r < 6) begin
                cycle(cur ^ (4'h1 << $urandom_range(0, 3)));
            end else if (r == 99 && $urandom_range(0, 4) == 0) begin
                async_reset("rand_rst_outs");
            end else begin
                cycle(cur);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
